// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes / InvSubBytes engine: LANES bytes of the 128-bit state
// are substituted per clock, lowest bytes first, with valid/ready on both sides.

// One byte of S-box (and optionally inverse S-box), computed as GF(2^8)
// inversion plus the affine map rather than a 256-entry table.
module sub_bytes_lane #(
    parameter int INV_EN = 1
) (
    input  logic [7:0] din,
    input  logic       mode,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] fwd;
    assign fwd = affine(gf_inv(din));

    generate
        if (INV_EN != 0) begin : g_inv
            logic [7:0] rev;
            assign rev  = gf_inv(inv_affine(din));
            assign dout = mode ? rev : fwd;
        end else begin : g_fwd
            logic unused_mode;
            assign unused_mode = mode;
            assign dout        = fwd;
        end
    endgenerate

endmodule

module sub_bytes_seq #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int NSTEP = (LANES > 0) ? 16 / LANES : 1;
    localparam int IDX_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [LANES-1:0][7:0] chunk_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic                    mode_q;
    logic [NSTEP-1:0][LANES*8-1:0] st_q, st_step;
    chunk_t                  cur, sub;
    logic                    accept, load, step;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign data_out  = st_q;

    // Slice currently being substituted, and the state with that slice replaced.
    generate
        if (NSTEP == 1) begin : g_one_step
            assign cur     = st_q[0];
            assign st_step = sub;
        end else begin : g_multi_step
            assign cur = st_q[idx_q];
            always_comb begin
                st_step        = st_q;
                st_step[idx_q] = sub;
            end
        end
    endgenerate

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sub_bytes_lane #(.INV_EN(INV_EN)) u_lane (
            .din  (cur[l]),
            .mode (mode_q),
            .dout (sub[l])
        );
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (idx_q == IDX_W'(NSTEP - 1)) state_d = DONE;
            end
            DONE: begin
                // accept here already implies out_ready, so a new block chains in.
                if (accept) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                st_q   <= data_in;
                mode_q <= (INV_EN != 0) && inv;
                idx_q  <= '0;
            end else if (step) begin
                st_q  <= st_step;
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule
